aes_core_scheduler: RTL

//  Shares one fully pipelined AES encryption core among NUM_REQ requesters. Round-robin arbiter

---
 rtl/aes_sched_pkg.sv | 24 ++
 rtl/aes_sched_rr_arb.sv | 36 +++
 rtl/aes_core_scheduler.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES core scheduler.
package aes_sched_pkg;

   // Scheduler FSM: normal issue, wait for the core to empty, retarget keylen.
   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_SWITCH = 2'd2
   } sched_state_e;

   // Key-length encoding on req_keylen / core_keylen.
   localparam logic KEYLEN_128 = 1'b0;
   localparam logic KEYLEN_256 = 1'b1;

   // Width of a requester index; never narrower than one bit.
   function automatic int id_w(input int n);
      if (n <= 2) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/aes_sched_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr_i,
// wrapping modulo NUM_REQ. Produces a one-hot grant and the winner index.
module aes_sched_rr_arb #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]    idx_o,
   output logic               any_o
);

   logic [ID_W-1:0] cand_s;
   logic            found_s;

   // Walk the requesters starting at the pointer and keep the first valid one.
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      found_s = 1'b0;
      cand_s  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand_s = ID_W'((int'(ptr_i) + i) % NUM_REQ);
         if (!found_s && req_i[cand_s]) begin
            found_s       = 1'b1;
            idx_o         = cand_s;
            gnt_o[cand_s] = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
      any_o = found_s;
   end

endmodule

// File: rtl/aes_core_scheduler.sv
// Shares one pipelined AES core among NUM_REQ requesters. Round-robin
// arbitration, one issue per cycle, in-flight requester tags kept in a
// circular FIFO so results come back labelled with resp_id. Because the
// core's key length is a static input, a key-length change drains the core
// before core_keylen switches.
// Optional feature: define AES_SCHED_LATCHK_EN to flag any core result that
// does not arrive exactly CORE_LATENCY cycles after its issue.
module aes_core_scheduler
   import aes_sched_pkg::*;
#(
   parameter int   NUM_REQ      = 4,
   parameter int   DATA_WIDTH   = 128,
   parameter int   KEY_WIDTH    = 256,
   parameter int   CORE_LATENCY = 15,
   parameter int   TAG_DEPTH    = 16,
   parameter logic KEYLEN_RST   = KEYLEN_256,
   localparam int  ID_W         = id_w(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_plaintext,
   input  logic [NUM_REQ*KEY_WIDTH-1:0]  req_key,
   input  logic [NUM_REQ-1:0]            req_keylen,
   output logic                          core_valid_in,
   output logic [DATA_WIDTH-1:0]         core_plaintext,
   output logic [KEY_WIDTH-1:0]          core_key,
   output logic                          core_keylen,
   input  logic                          core_valid_out,
   input  logic [DATA_WIDTH-1:0]         core_ciphertext,
   output logic                          resp_valid,
   output logic [ID_W-1:0]               resp_id,
   output logic [DATA_WIDTH-1:0]         resp_data,
   output logic                          busy,
   output logic                          err
);

   localparam int AW = $clog2(TAG_DEPTH);
   localparam int CW = AW + 1;

   // FSM and arbitration state
   sched_state_e    state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0] sw_id_q, sw_id_d;
   logic            keylen_q, keylen_d;
   logic [CW-1:0]   inflight_q, inflight_d;

   // Issue stage registers
   logic                  issue_q;
   logic [ID_W-1:0]       issue_id_q;
   logic [DATA_WIDTH-1:0] pt_q;
   logic [KEY_WIDTH-1:0]  key_q;

   // Tag FIFO; pointers carry one extra wrap bit so full and empty differ
   logic [ID_W-1:0] tag_mem_q [TAG_DEPTH];
   logic [CW-1:0]   wr_ptr_q, rd_ptr_q;

   // Response and error registers
   logic                  resp_valid_q;
   logic [ID_W-1:0]       resp_id_q;
   logic [DATA_WIDTH-1:0] resp_data_q;
   logic                  err_q;

   // Combinational helpers
   logic [NUM_REQ-1:0] gnt_s;
   logic [ID_W-1:0]    win_idx_s;
   logic               win_any_s;
   logic               win_keylen_s;
   logic               grant_s;
   logic               full_s;
   logic               fifo_empty_s;
   logic               pop_s;
   logic               bad_pop_s;
   logic               lat_err_s;

   aes_sched_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arb (
      .req_i (req_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (gnt_s),
      .idx_o (win_idx_s),
      .any_o (win_any_s)
   );

   assign win_keylen_s = req_keylen[win_idx_s];
   assign full_s       = (inflight_q == CW'(TAG_DEPTH));
   assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
   assign pop_s        = core_valid_out & ~fifo_empty_s;
   assign bad_pop_s    = core_valid_out & fifo_empty_s;

   // Next-state logic: grant in RUN, hold off during DRAIN, retarget keylen in SWITCH.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      sw_id_d   = sw_id_q;
      keylen_d  = keylen_q;
      grant_s   = 1'b0;
      req_ready = '0;
      case (state_q)
         ST_RUN: begin
            if (win_any_s) begin
               if (win_keylen_s != keylen_q) begin
                  // Remember who asked for the new key length; it goes first after the switch.
                  state_d = ST_DRAIN;
                  sw_id_d = win_idx_s;
               end else if (!full_s) begin
                  grant_s   = 1'b1;
                  req_ready = gnt_s;
                  if (win_idx_s == ID_W'(NUM_REQ - 1)) begin
                     rr_ptr_d = '0;
                  end else begin
                     rr_ptr_d = win_idx_s + ID_W'(1);
                  end
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if ((inflight_q == '0) && !core_valid_out) begin
               state_d = ST_SWITCH;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_SWITCH: begin
            keylen_d = req_keylen[sw_id_q];
            rr_ptr_d = sw_id_q;
            state_d  = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // In-flight count: grants add, returned results remove.
   always_comb begin
      inflight_d = inflight_q;
      case ({grant_s, pop_s})
         2'b10:   inflight_d = inflight_q + CW'(1);
         2'b01:   inflight_d = inflight_q - CW'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_RUN;
         rr_ptr_q   <= '0;
         sw_id_q    <= '0;
         keylen_q   <= KEYLEN_RST;
         inflight_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         sw_id_q    <= sw_id_d;
         keylen_q   <= keylen_d;
         inflight_q <= inflight_d;
      end
   end

   // Issue register: capture the winner's block and key the cycle after the handshake.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         issue_q    <= 1'b0;
         issue_id_q <= '0;
         pt_q       <= '0;
         key_q      <= '0;
      end else begin
         issue_q <= grant_s;
         if (grant_s) begin
            issue_id_q <= win_idx_s;
            pt_q       <= req_plaintext[int'(win_idx_s)*DATA_WIDTH +: DATA_WIDTH];
            key_q      <= req_key[int'(win_idx_s)*KEY_WIDTH +: KEY_WIDTH];
         end else begin
            issue_id_q <= issue_id_q;
            pt_q       <= pt_q;
            key_q      <= key_q;
         end
      end
   end

   // Tag FIFO storage: write the owner of each block as it enters the core.
   always_ff @(posedge clk) begin
      if (issue_q) begin
         tag_mem_q[wr_ptr_q[AW-1:0]] <= issue_id_q;
      end else begin
         tag_mem_q[wr_ptr_q[AW-1:0]] <= tag_mem_q[wr_ptr_q[AW-1:0]];
      end
   end

   // Tag FIFO pointers; reset discards every in-flight tag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= issue_q ? (wr_ptr_q + CW'(1)) : wr_ptr_q;
         rd_ptr_q <= pop_s   ? (rd_ptr_q + CW'(1)) : rd_ptr_q;
      end
   end

   // Response register: pair each core result with the oldest tag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_data_q  <= '0;
      end else begin
         resp_valid_q <= pop_s;
         if (pop_s) begin
            resp_id_q   <= tag_mem_q[rd_ptr_q[AW-1:0]];
            resp_data_q <= core_ciphertext;
         end else begin
            resp_id_q   <= resp_id_q;
            resp_data_q <= resp_data_q;
         end
      end
   end

`ifdef AES_SCHED_LATCHK_EN
   logic [CORE_LATENCY-1:0] lat_sr_q;

   // Issue history: the top bit marks a result that is due this cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lat_sr_q <= '0;
      end else begin
         lat_sr_q <= (lat_sr_q << 1) | CORE_LATENCY'(issue_q);
      end
   end

   assign lat_err_s = (core_valid_out != lat_sr_q[CORE_LATENCY-1]);
`else
   assign lat_err_s = 1'b0;
`endif

   // Sticky error: a result with no owner, or one arriving off schedule.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_q | bad_pop_s | lat_err_s;
      end
   end

   assign core_valid_in  = issue_q;
   assign core_plaintext = pt_q;
   assign core_key       = key_q;
   assign core_keylen    = keylen_q;
   assign resp_valid     = resp_valid_q;
   assign resp_id        = resp_id_q;
   assign resp_data      = resp_data_q;
   assign err            = err_q;
   assign busy           = (inflight_q != '0) | (|req_valid);

endmodule
